// File: rtl/dmem_pkg.sv
// Shared definitions for the multi-cycle data memory: RV32I width codes,
// FSM state encoding and the funct3 legality check.
package dmem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Stores accept only B/H/W; loads additionally accept the unsigned forms.
  function automatic logic legal_funct3(input logic write, input logic [2:0] f3);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !write;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane steering: store byte enables / replicated write data,
// and load byte/half extraction with sign or zero extension.
module lsu_align
  import dmem_pkg::*;
(
  input  logic [2:0]  wr_funct3,
  input  logic [1:0]  wr_addr_lo,
  input  logic [31:0] wr_data,
  output logic [3:0]  wr_be,
  output logic [31:0] wr_data_sh,
  input  logic [2:0]  rd_funct3,
  input  logic [1:0]  rd_addr_lo,
  input  logic [31:0] rd_word,
  output logic [31:0] rd_data
);

  logic [7:0]  rd_byte [4];
  logic [7:0]  sel_byte;
  logic [15:0] sel_half;

  for (genvar gi = 0; gi < 4; gi++) begin : g_lane
    assign rd_byte[gi] = rd_word[8*gi +: 8];
  end

  // Halfword lane ignores addr[0]; word accesses ignore both low bits.
  assign sel_byte = rd_byte[rd_addr_lo];
  assign sel_half = rd_addr_lo[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    wr_be      = 4'b0000;
    wr_data_sh = 32'h0;
    case (wr_funct3)
      F3_B: begin
        wr_be      = 4'b0001 << wr_addr_lo;
        wr_data_sh = {4{wr_data[7:0]}};
      end
      F3_H: begin
        wr_be      = wr_addr_lo[1] ? 4'b1100 : 4'b0011;
        wr_data_sh = {2{wr_data[15:0]}};
      end
      F3_W: begin
        wr_be      = 4'b1111;
        wr_data_sh = wr_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    rd_data = 32'h0;
    case (rd_funct3)
      F3_B:    rd_data = {{24{sel_byte[7]}}, sel_byte};
      F3_H:    rd_data = {{16{sel_half[15]}}, sel_half};
      F3_W:    rd_data = rd_word;
      F3_BU:   rd_data = {24'h0, sel_byte};
      F3_HU:   rd_data = {16'h0, sel_half};
      default: rd_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/data_memory_mc.sv
// Multi-cycle data memory with valid/ready request and one-cycle response pulse.
// Define DMEM_MISALIGN_TRAP_EN to fault misaligned halfword/word accesses.
module data_memory_mc
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int ADDR_W      = 32,
  parameter int LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_funct3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              resp_valid,
  output logic [31:0]       resp_rdata,
  output logic              resp_fault
);

  localparam int              IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [ADDR_W:0] BYTE_CAP = (ADDR_W+1)'(DEPTH_WORDS * 4);
  localparam logic [3:0]      CNT_INIT = 4'(LATENCY - 1);

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic              write_reg;
  logic [2:0]        funct3_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [31:0]       wdata_reg;
  logic              req_ready_reg;
  logic              resp_valid_reg;
  logic              resp_fault_reg;
  logic              resp_load_reg;

  logic [31:0]       mem [DEPTH_WORDS];
  logic [31:0]       rd_word_reg;

  logic              accept;
  logic              enter_resp;
  logic              cur_write;
  logic [2:0]        cur_funct3;
  logic [ADDR_W-1:0] cur_addr;
  logic [31:0]       cur_wdata;
  logic [IDX_W-1:0]  cur_idx;
  logic              range_fault;
  logic              align_fault;
  logic              cur_fault;
  logic [3:0]        wr_be;
  logic [31:0]       wr_data_sh;
  logic [31:0]       ld_data;

  assign accept = req_valid && req_ready_reg && (state_reg == ST_IDLE);

  // With LATENCY==1 the commit edge is the acceptance edge, so the live
  // request inputs are used there instead of the captured copies.
  assign cur_write  = accept ? req_write  : write_reg;
  assign cur_funct3 = accept ? req_funct3 : funct3_reg;
  assign cur_addr   = accept ? req_addr   : addr_reg;
  assign cur_wdata  = accept ? req_wdata  : wdata_reg;
  assign cur_idx    = cur_addr[IDX_W+1:2];

  assign enter_resp = (accept && (LATENCY == 1)) ||
                      ((state_reg == ST_WAIT) && (cnt_reg == 4'd1));

  assign range_fault = {1'b0, cur_addr} >= BYTE_CAP;
`ifdef DMEM_MISALIGN_TRAP_EN
  assign align_fault = ((cur_funct3[1:0] == 2'b01) && cur_addr[0]) ||
                       ((cur_funct3[1:0] == 2'b10) && (cur_addr[1:0] != 2'b00));
`else
  assign align_fault = 1'b0;
`endif
  assign cur_fault = range_fault || align_fault || !legal_funct3(cur_write, cur_funct3);

  lsu_align u_align (
    .wr_funct3  (cur_funct3),
    .wr_addr_lo (cur_addr[1:0]),
    .wr_data    (cur_wdata),
    .wr_be      (wr_be),
    .wr_data_sh (wr_data_sh),
    .rd_funct3  (funct3_reg),
    .rd_addr_lo (addr_reg[1:0]),
    .rd_word    (rd_word_reg),
    .rd_data    (ld_data)
  );

  always_ff @(posedge clk) begin
    if (enter_resp && !rst) begin
      if (cur_write && !cur_fault) begin
        for (int b = 0; b < 4; b++) begin
          if (wr_be[b]) mem[cur_idx][8*b +: 8] <= wr_data_sh[8*b +: 8];
        end
      end
      rd_word_reg <= mem[cur_idx];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= ST_IDLE;
      cnt_reg        <= 4'd0;
      write_reg      <= 1'b0;
      funct3_reg     <= 3'd0;
      addr_reg       <= '0;
      wdata_reg      <= 32'h0;
      req_ready_reg  <= 1'b0;
      resp_valid_reg <= 1'b0;
      resp_fault_reg <= 1'b0;
      resp_load_reg  <= 1'b0;
    end else begin
      resp_valid_reg <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          req_ready_reg <= 1'b1;
          if (accept) begin
            write_reg     <= req_write;
            funct3_reg    <= req_funct3;
            addr_reg      <= req_addr;
            wdata_reg     <= req_wdata;
            cnt_reg       <= CNT_INIT;
            req_ready_reg <= 1'b0;
            state_reg     <= (LATENCY == 1) ? ST_RESP : ST_WAIT;
          end
        end
        ST_WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_reg <= ST_RESP;
        end
        ST_RESP: begin
          state_reg     <= ST_IDLE;
          req_ready_reg <= 1'b1;
        end
        default: state_reg <= ST_IDLE;
      endcase
      if (enter_resp) begin
        resp_valid_reg <= 1'b1;
        resp_fault_reg <= cur_fault;
        resp_load_reg  <= !cur_write && !cur_fault;
      end
    end
  end

  assign req_ready  = req_ready_reg;
  assign resp_valid = resp_valid_reg;
  assign resp_fault = resp_fault_reg;
  assign resp_rdata = resp_load_reg ? ld_data : 32'h0;

endmodule

// File: tb/tb_data_memory_mc.sv
// Scoreboard bench for data_memory_mc: byte-array reference model, directed
// and random requests, handshake/reset checks and a LATENCY=1 instance.
module tb_data_memory_mc;

  localparam int DW  = 64;
  localparam int LAT = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_ready, req_write;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic        resp_valid, resp_fault;
  logic [31:0] resp_rdata;

  logic        req_valid1, req_ready1, req_write1;
  logic [2:0]  req_funct31;
  logic [31:0] req_addr1, req_wdata1;
  logic        resp_valid1, resp_fault1;
  logic [31:0] resp_rdata1;

  always #5 clk = ~clk;

  data_memory_mc #(.DEPTH_WORDS(DW), .ADDR_W(32), .LATENCY(LAT)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_write(req_write), .req_funct3(req_funct3), .req_addr(req_addr),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
    .resp_fault(resp_fault)
  );

  data_memory_mc #(.DEPTH_WORDS(DW), .ADDR_W(32), .LATENCY(1)) dut1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_ready(req_ready1),
    .req_write(req_write1), .req_funct3(req_funct31), .req_addr(req_addr1),
    .req_wdata(req_wdata1), .resp_valid(resp_valid1), .resp_rdata(resp_rdata1),
    .resp_fault(resp_fault1)
  );

  typedef struct {
    logic [31:0] rd;
    logic        fault;
    int          t;
    string       name;
  } exp_t;

  exp_t        sb[$];
  logic [7:0]  model_mem [DW*4];
  int          checks = 0;
  int          passes = 0;
  int          cyc = 0;
  int          resp_seen = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
  endtask

  // Reference: memory as a flat byte array, accesses from the ISA rules.
  function automatic void model(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                                input logic [31:0] wd, output logic [31:0] rd, output logic fault);
    int          nbytes;
    logic [31:0] base, val, mask;
    fault = (addr >= 32'(DW*4));
    if (w) fault = fault || (f3 > 3'd2);
    else   fault = fault || !(f3 <= 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    nbytes = 1 << f3[1:0];
`ifdef DMEM_MISALIGN_TRAP_EN
    if (addr % nbytes != 0) fault = 1'b1;
`endif
    rd = 32'h0;
    if (fault) return;
    base = addr - (addr % nbytes);
    if (w) begin
      for (int i = 0; i < nbytes; i++) model_mem[int'(base) + i] = wd[8*i +: 8];
    end else begin
      val = 32'h0;
      for (int i = 0; i < nbytes; i++) val = val | (32'(model_mem[int'(base) + i]) << (8*i));
      if (nbytes < 4) begin
        mask = (32'd1 << (8*nbytes)) - 32'd1;
        if (!f3[2] && val[8*nbytes-1]) val = val | ~mask;
      end
      rd = val;
    end
  endfunction

  task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wd, input string name, output int t_acc);
    int          n;
    logic [31:0] rd;
    logic        flt;
    exp_t        e;
    @(negedge clk);
    req_valid  = 1'b1;
    req_write  = w;
    req_funct3 = f3;
    req_addr   = addr;
    req_wdata  = wd;
    n = 0;
    while (!req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    t_acc = cyc;
    if (!req_ready) begin
      checks++;
      $display("FAIL %s accept_timeout: ready=0 required=1", name);
      return;
    end
    model(w, f3, addr, wd, rd, flt);
    e.rd = rd; e.fault = flt; e.t = cyc; e.name = name;
    sb.push_back(e);
    $display("req %s w=%0d f3=%0d addr=0x%08h wdata=0x%08h exp_rd=0x%08h exp_fault=%0d",
             name, w, f3, addr, wd, rd, flt);
    @(posedge clk);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (resp_valid) begin
      resp_seen++;
      check("ready_low_in_resp", 32'(req_ready), 32'd0);
      if (sb.size() == 0) begin
        checks++;
        $display("FAIL unexpected_resp: rdata=0x%08h fault=%0d with no request pending",
                 resp_rdata, resp_fault);
      end else begin
        e = sb.pop_front();
        $display("resp %s rdata=0x%08h fault=%0d lat=%0d", e.name, resp_rdata, resp_fault, cyc - e.t);
        check({e.name, "_rdata"}, resp_rdata, e.rd);
        check({e.name, "_fault"}, 32'(resp_fault), 32'(e.fault));
        check({e.name, "_latency"}, 32'(cyc - e.t), 32'(LAT));
      end
    end
  end

  task automatic issue1(input logic w, input logic [2:0] f3, input logic [31:0] addr,
                        input logic [31:0] wd, output logic [31:0] rd, output logic flt,
                        output int lat);
    int n, t;
    @(negedge clk);
    req_valid1 = 1'b1; req_write1 = w; req_funct31 = f3; req_addr1 = addr; req_wdata1 = wd;
    n = 0;
    while (!req_ready1 && n < 20) begin @(negedge clk); n++; end
    t = cyc;
    @(posedge clk);
    @(negedge clk);
    req_valid1 = 1'b0;
    n = 0;
    while (!resp_valid1 && n < 20) begin @(negedge clk); n++; end
    rd = resp_rdata1; flt = resp_fault1; lat = resp_valid1 ? (cyc - t) : -1;
    $display("lat1 w=%0d addr=0x%08h rdata=0x%08h fault=%0d lat=%0d", w, addr, rd, flt, lat);
  endtask

  initial begin
    int          t, prev_t, seen0, n, lat;
    logic        w, flt;
    logic [2:0]  f3;
    logic [31:0] a, rd;

    rst = 1'b1;
    req_valid = 1'b0; req_write = 1'b0; req_funct3 = 3'd0; req_addr = 32'h0; req_wdata = 32'h0;
    req_valid1 = 1'b0; req_write1 = 1'b0; req_funct31 = 3'd0; req_addr1 = 32'h0; req_wdata1 = 32'h0;
    for (int i = 0; i < DW*4; i++) model_mem[i] = 8'h00;
    repeat (3) @(negedge clk);
    check("reset_ready", 32'(req_ready), 32'd0);
    check("reset_resp_valid", 32'(resp_valid), 32'd0);
    check("reset_rdata", resp_rdata, 32'h0);
    check("reset_fault", 32'(resp_fault), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < DW; i++) issue(1'b1, 3'd2, 32'(4*i), 32'h0, "zero_fill", t);

    issue(1'b1, 3'd2, 32'd100, 32'h11223344, "sw100", t);
    issue(1'b0, 3'd2, 32'd100, 32'h0, "lw100", t);
    issue(1'b1, 3'd0, 32'd200, 32'h000000AA, "sb200", t);
    issue(1'b0, 3'd0, 32'd200, 32'h0, "lb200", t);
    issue(1'b0, 3'd4, 32'd200, 32'h0, "lbu200", t);
    issue(1'b1, 3'd1, 32'd102, 32'h00008001, "sh102", t);
    issue(1'b0, 3'd1, 32'd102, 32'h0, "lh102", t);
    issue(1'b0, 3'd5, 32'd102, 32'h0, "lhu102", t);
    issue(1'b0, 3'd2, 32'd100, 32'h0, "lw100_b", t);
    issue(1'b0, 3'd2, 32'd256, 32'h0, "lw256_range", t);
    issue(1'b0, 3'd3, 32'd100, 32'h0, "lw_f3_011", t);
    issue(1'b1, 3'd2, 32'd300, 32'h12345678, "sw300_range", t);
    issue(1'b1, 3'd4, 32'd100, 32'hFFFFFFFF, "st_f3_100", t);
    issue(1'b0, 3'd2, 32'd100, 32'h0, "lw100_unchanged", t);
    issue(1'b0, 3'd2, 32'd101, 32'h0, "lw101_misalign", t);
    issue(1'b0, 3'd1, 32'd103, 32'h0, "lh103_misalign", t);

    // Held-valid random burst: one acceptance every LAT+1 cycles.
    prev_t = 0;
    for (int i = 0; i < 60; i++) begin
      w  = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DW*4 + 20));
      issue(w, f3, a, $urandom, "rand", t);
      if (i > 0) check("burst_gap", 32'(t - prev_t), 32'(LAT + 1));
      prev_t = t;
    end

    // Reset during WAIT of a store; req_valid stays high through reset.
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'd2; req_addr = 32'd8; req_wdata = 32'hDEADBEEF;
    n = 0;
    while (!req_ready && n < 20) begin @(negedge clk); n++; end
    check("rst_test_accept_ready", 32'(req_ready), 32'd1);
    @(posedge clk);
    seen0 = resp_seen;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_ready", 32'(req_ready), 32'd0);
    check("midrst_resp_valid", 32'(resp_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    req_valid = 1'b0;
    repeat (6) @(negedge clk);
    check("midrst_no_resp", 32'(resp_seen - seen0), 32'd0);
    $display("reset_drop resp_count_delta=%0d", resp_seen - seen0);
    issue(1'b0, 3'd2, 32'd8, 32'h0, "lw8_after_rst", t);

    @(negedge clk);
    req_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 20) begin @(negedge clk); n++; end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    issue1(1'b1, 3'd2, 32'd4, 32'hCAFEF00D, rd, flt, lat);
    check("lat1_sw_latency", 32'(lat), 32'd1);
    check("lat1_sw_fault", 32'(flt), 32'd0);
    issue1(1'b0, 3'd2, 32'd4, 32'h0, rd, flt, lat);
    check("lat1_lw_latency", 32'(lat), 32'd1);
    check("lat1_lw_rdata", rd, 32'hCAFEF00D);
    issue1(1'b0, 3'd1, 32'd6, 32'h0, rd, flt, lat);
    check("lat1_lh_rdata", rd, 32'hFFFFCAFE);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule

// File: doc/data_memory_mc.md
Name: data_memory_mc

Overview:
- Parametrised, multi-cycle successor to the single-cycle data memory used by the MEM stage.
- Accepts one load/store request at a time over a valid/ready handshake.
- Models a configurable access latency so the pipeline's stall logic can be exercised.
- Returns sign/zero-extended load data, or an access fault, on a one-cycle response pulse.

Parameters:
- DEPTH_WORDS, 256: number of 32-bit words; byte capacity is DEPTH_WORDS*4.
- ADDR_W, 32: width of the request byte address.
- LATENCY, 2: cycles from request acceptance to response; legal range 1..15.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1=store, 0=load
- req_funct3  in  3  RV32I width code. Loads: LB 000, LH 001, LW 010, LBU 100, LHU 101. Stores: SB 000, SH 001, SW 010.
- req_addr  in  ADDR_W  byte address, little-endian
- req_wdata  in  32  store data; low byte/half/word used
- resp_valid  out  1  one-cycle response pulse
- resp_rdata  out  32  extended load data; 0 for stores and faults
- resp_fault  out  1  request faulted; qualified by resp_valid

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset values: state=IDLE, req_ready=0 while rst=1, resp_valid=0, resp_rdata=0, resp_fault=0, latency counter=0.
- Memory array is not reset; in simulation it is initialised to zero.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: req_ready=1. On req_valid&&req_ready, capture write, funct3, addr and wdata; load cnt=LATENCY-1. Go to RESP if LATENCY==1, else to WAIT.
  - WAIT: req_ready=0. cnt decrements each cycle; at cnt==1, go to RESP.
  - RESP: resp_valid=1 for exactly one cycle, req_ready=0. Next state is IDLE.
- Timing: a request accepted at edge N gives resp_valid=1 during the cycle after edge N+LATENCY-1, so exactly LATENCY cycles after acceptance.
- Throughput: at most one request per LATENCY+1 cycles.
- There is no response backpressure.
- Store commit: bytes are written at the edge that enters RESP, only if no fault.
  - SB writes lane addr[1:0].
  - SH writes lanes {addr[1],0} and {addr[1],1}.
  - SW writes all 4 lanes.
- Load data: read from the array at the edge entering RESP and registered onto resp_rdata.
  - LB/LH: sign-extended.
  - LBU/LHU: zero-extended.
  - A load immediately after a store to the same address returns the new data.
- Fault conditions (always active): any of the following sets resp_fault=1, resp_rdata=0, and performs no write.
  - Byte address >= DEPTH_WORDS*4, evaluated on the full ADDR_W address.
  - Illegal funct3: loads 011/110/111; stores other than 000/001/010.
- Input changes while req_ready=0 are ignored; captured values are held internally.
- Reset mid-operation: a pending request is dropped with no response. A store is not committed unless its commit edge has already occurred.
- Reset and req_valid in the same cycle: the request is not accepted.

Optional Feature:
- Macro: DMEM_MISALIGN_TRAP_EN.
- Defined: LH/LHU/SH with addr[0]!=0, or LW/SW with addr[1:0]!=0, sets resp_fault=1 with no write and rdata=0.
- Undefined: misaligned low address bits are ignored. Halfword accesses use addr&~1, word accesses use addr&~3, and no fault is raised for alignment.

Decomposition:
- Package dmem_pkg holds:
  - funct3 localparams (F3_B, F3_H, F3_W, F3_BU, F3_HU);
  - FSM state encoding (ST_IDLE, ST_WAIT, ST_RESP);
  - function legal_funct3(write, f3).
- Sub-module lsu_align (combinational) provides:
  - from funct3 and addr[1:0]: the byte-lane write enables and shifted write data;
  - from the raw word: the extracted, extended load data.
- FSM and array stay in data_memory_mc.

Test Plan (DEPTH_WORDS=64, LATENCY=2 unless noted):
- SW addr=100 wdata=0x11223344, then LW addr=100 -> each resp_valid arrives exactly 2 cycles after acceptance; LW rdata=0x11223344, fault=0.
- SB addr=200 wdata=0xAA, then LB addr=200 -> 0xFFFFFFAA; LBU addr=200 -> 0x000000AA.
- SH addr=102 wdata=0x8001, then LH addr=102 -> 0xFFFF8001; LHU addr=102 -> 0x00008001; LW addr=100 -> 0x80013344.
- LW addr=256 (out of range), then LW funct3=011 -> both fault=1, rdata=0; the array is unchanged.
- LW addr=101: with DMEM_MISALIGN_TRAP_EN -> fault=1; without it -> rdata=0x80013344, fault=0.
- Handshake and reset:
  - With req_valid held high, verify req_ready=0 during WAIT/RESP, with one acceptance every 3 cycles.
  - Assert rst during WAIT of SW addr=8 wdata=0xDEADBEEF -> no resp_valid. A subsequent LW addr=8 -> 0x00000000.
  - With LATENCY=1, a response follows 1 cycle after acceptance.
